// File: rtl/parallel_to_serial.sv
// Word-to-chunk serializer: accepts a WIDTH-bit word and emits WIDTH/DATA_SIZE chunks.
// Define P2S_LSB_FIRST_EN to emit least-significant chunk first (default is MSB first).
module parallel_to_serial #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     D,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] Q,
    output logic                 last,
    output logic                 busy
);

    localparam int unsigned COUNT = WIDTH / DATA_SIZE;
    localparam int unsigned CntW  = $clog2(COUNT) + 1;

    typedef enum logic {StIdle, StShift} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] chunk;
    logic [WIDTH-1:0]    shreg_next;
    logic                is_last;

    always_comb begin
`ifdef P2S_LSB_FIRST_EN
        chunk      = shreg_q[DATA_SIZE-1:0];
        shreg_next = shreg_q >> DATA_SIZE;
`else
        chunk      = shreg_q[WIDTH-1 -: DATA_SIZE];
        shreg_next = shreg_q << DATA_SIZE;
`endif
    end

    always_comb begin
        is_last   = (state_q == StShift) && (cnt_q == CntW'(1));
        busy      = (state_q == StShift);
        out_valid = (state_q == StShift);
        last      = is_last;
        Q         = (state_q == StShift) ? chunk : '0;
        // Ready in IDLE, or on the last-chunk handoff so words stream without a bubble
        in_ready  = rst_n && !load &&
                    ((state_q == StIdle) || (out_ready && is_last));
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = StIdle;
            shreg_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_d = StShift;
                        shreg_d = D;
                        cnt_d   = CntW'(COUNT);
                    end
                end
                StShift: begin
                    if (out_ready) begin
                        if (!is_last) begin
                            shreg_d = shreg_next;
                            cnt_d   = cnt_q - CntW'(1);
                        end else if (in_valid) begin
                            shreg_d = D;
                            cnt_d   = CntW'(COUNT);
                        end else begin
                            state_d = StIdle;
                            shreg_d = '0;
                            cnt_d   = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench for parallel_to_serial: accepted words push expected chunks, a monitor pops them.
// Honours P2S_LSB_FIRST_EN for chunk order.
module tb_parallel_to_serial;

    localparam int DS = 8;
    localparam int W  = 32;
    localparam int N  = W / DS;
`ifdef P2S_LSB_FIRST_EN
    localparam logic [DS-1:0] FIRST_DEADBEEF = 8'hEF;
`else
    localparam logic [DS-1:0] FIRST_DEADBEEF = 8'hDE;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  D = '0;
    logic          in_ready, out_valid, last, busy;
    logic [DS-1:0] Q;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DS:0] exp_q[$];
    int          xfer_cyc[$];
    bit          rdy_log[$];
    logic        prev_stall = 1'b0;
    logic [DS:0] prev_out = '0;
    logic [DS:0] mon_e;

    parallel_to_serial #(.DATA_SIZE(DS), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .last      (last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DS-1:0] chunk_of(input logic [W-1:0] w, input int i);
`ifdef P2S_LSB_FIRST_EN
        return w[i*DS +: DS];
`else
        return w[W-1-i*DS -: DS];
`endif
    endfunction

    // Monitor: pop on each chunk transfer, push on each word transfer
    always @(negedge clk) begin
        cyc++;
        if (!rst_n || load) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) check("stall_hold", {Q, last}, prev_out);
            if (out_valid && out_ready) begin
                check("chunk_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("chunk", {Q, last}, mon_e);
                end
                xfer_cyc.push_back(cyc);
                rdy_log.push_back(in_ready);
            end
            if (in_valid && in_ready)
                for (int i = 0; i < N; i++) exp_q.push_back({chunk_of(D, i), i == N - 1});
            prev_stall = out_valid && !out_ready;
            prev_out   = {Q, last};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        in_valid = 1'b1;
        D        = w;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            tick();
            if (exp_q.size() == 0) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d pending chunks expected 0", exp_q.size());
    endtask

    initial begin
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Power-on reset
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_q", Q, 0);
        check("rst_busy", busy, 0);
        check("rst_last", last, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        tick();

        // Straight MSB/LSB-first word at full rate
        xfer_cyc.delete();
        send_word(32'hDEADBEEF);
        in_valid = 1'b0;
        @(negedge clk);
        check("first_latency_valid", out_valid, 1);
        check("first_chunk", Q, FIRST_DEADBEEF);
        drain();
        check("w1_xfers", xfer_cyc.size(), 4);
        if (xfer_cyc.size() == 4) check("w1_span", xfer_cyc[3] - xfer_cyc[0], 3);
        check("w1_idle_busy", busy, 0);
        check("w1_idle_valid", out_valid, 0);
        check("w1_idle_q", Q, 0);

        // Backpressure pattern
        xfer_cyc.delete();
        send_word(32'hDEADBEEF);
        in_valid = 1'b0;
        foreach (pat[i]) begin
            out_ready = pat[i];
            tick();
        end
        out_ready = 1'b1;
        check("bp_xfers", xfer_cyc.size(), 4);
        check("bp_busy", busy, 0);
        check("bp_pending", exp_q.size(), 0);

        // Back-to-back words, no bubble
        xfer_cyc.delete();
        rdy_log.delete();
        send_word(32'h01020304);
        send_word(32'hA0B0C0D0);
        in_valid = 1'b0;
        drain();
        check("b2b_xfers", xfer_cyc.size(), 8);
        if (xfer_cyc.size() == 8) begin
            check("b2b_span", xfer_cyc[7] - xfer_cyc[0], 7);
            for (int i = 0; i < 8; i++) check("b2b_in_ready", rdy_log[i], (i == 3 || i == 7));
        end

        // Abort with load after two chunks; coincident word must be dropped
        send_word(32'hDEADBEEF);
        in_valid = 1'b0;
        repeat (2) tick();
        load     = 1'b1;
        in_valid = 1'b1;
        D        = 32'hCAFEF00D;
        @(negedge clk);
        check("load_in_ready", in_ready, 0);
        tick();
        load     = 1'b0;
        in_valid = 1'b0;
        check("load_valid", out_valid, 0);
        check("load_busy", busy, 0);
        check("load_q", Q, 0);
        check("load_last", last, 0);
        xfer_cyc.delete();
        send_word(32'h11223344);
        in_valid = 1'b0;
        drain();
        check("post_load_xfers", xfer_cyc.size(), 4);

        // load in IDLE blocks an offered word
        load     = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("load_idle_in_ready", in_ready, 0);
        tick();
        load     = 1'b0;
        in_valid = 1'b0;
        check("load_idle_busy", busy, 0);

        // Async reset mid-word
        send_word(32'hDEADBEEF);
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_q", Q, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_rel_in_ready", in_ready, 1);
        check("arst_rel_valid", out_valid, 0);
        tick();
        check("arst_no_partial", out_valid, 0);

        check("final_pending", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
